// File: rtl/dp_ram_pkg.sv
// rtl/dp_ram_pkg.sv - shared types and constants for the dp_ram read path
package dp_ram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } rd_state_t;

    localparam int OUT_FIFO_DEPTH = 4;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dp_ram_stream_reader_if.sv
// rtl/dp_ram_stream_reader_if.sv - valid/ready word stream with last marker
interface dp_ram_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/dp_ram.sv
// rtl/dp_ram.sv - dual-port RAM, write port A, registered read port B
module dp_ram
    import dp_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH = 256,
    localparam int AW = addr_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_a,
    input  logic [AW-1:0]         addr_a,
    input  logic [DATA_WIDTH-1:0] din_a,
    input  logic [AW-1:0]         addr_b,
    output logic [DATA_WIDTH-1:0] dout_b
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[addr_a] <= din_a;
        end
        dout_b <= mem[addr_b];
    end
endmodule

// File: rtl/stream_fifo4.sv
// rtl/stream_fifo4.sv - 4-entry register FIFO carrying a data word and last flag
module stream_fifo4
    import dp_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_last,
    output logic                  empty,
    output logic [2:0]            count
);
    logic [DATA_WIDTH-1:0] data_mem [OUT_FIFO_DEPTH];
    logic                  last_mem [OUT_FIFO_DEPTH];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic                  do_pop;

    assign empty     = (count == 3'd0);
    assign do_pop    = pop && !empty;
    assign head_data = data_mem[rd_ptr];
    assign head_last = last_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUT_FIFO_DEPTH; i++) begin
                data_mem[i] <= '0;
                last_mem[i] <= 1'b0;
            end
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push) begin
                data_mem[wr_ptr] <= push_data;
                last_mem[wr_ptr] <= push_last;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/dp_ram_stream_reader.sv
// rtl/dp_ram_stream_reader.sv - walks a wrapped address range of dp_ram and streams the words
// out; a credit check keeps issued-but-unbuffered reads within the 4-entry output FIFO.
module dp_ram_stream_reader
    import dp_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH = 256,
    localparam int AW = addr_w(DEPTH)
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  start,
    input  logic [AW-1:0]         base_addr,
    input  logic [AW:0]           length,
    output logic                  busy,
    output logic                  done,
    output logic [AW-1:0]         rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    dp_ram_stream_reader_if.master m
);
    rd_state_t state, next_state;
    logic [AW:0] remaining;
    logic        issue_q, issue_last_q;
    logic        inflight, inflight_last;
    logic [2:0]  occupancy;
    logic [3:0]  committed;
    logic        accept, can_issue, pop, fifo_empty, head_last;

    assign accept    = (state == IDLE) && start;
    // issue_q: address on rd_addr this cycle is tracked; inflight: rd_data this cycle is tracked
    assign committed = 4'(occupancy) + 4'(issue_q) + 4'(inflight);
    assign can_issue = (state == RUN) && (remaining != '0) && (committed < 4'(OUT_FIFO_DEPTH));
    assign pop       = m.m_valid && m.m_ready;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign m.m_valid = !fifo_empty;
    assign m.m_last  = head_last && !fifo_empty;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = (length == '0) ? DONE : RUN;
            RUN:     if (remaining == '0) next_state = DRAIN;
            DRAIN:   if (pop && head_last) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rd_addr       <= '0;
            remaining     <= '0;
            issue_q       <= 1'b0;
            issue_last_q  <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            if (accept && (length != '0)) begin
                rd_addr      <= base_addr;
                remaining    <= length - (AW+1)'(1);
                issue_q      <= 1'b1;
                issue_last_q <= (length == (AW+1)'(1));
            end else if (can_issue) begin
                rd_addr      <= rd_addr + AW'(1);
                remaining    <= remaining - (AW+1)'(1);
                issue_q      <= 1'b1;
                issue_last_q <= (remaining == (AW+1)'(1));
            end else begin
                issue_q      <= 1'b0;
                issue_last_q <= 1'b0;
            end
            inflight      <= issue_q;
            inflight_last <= issue_last_q;
        end
    end

    stream_fifo4 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .push     (inflight),
        .push_data(rd_data),
        .push_last(inflight_last),
        .pop      (pop),
        .head_data(m.m_data),
        .head_last(head_last),
        .empty    (fifo_empty),
        .count    (occupancy)
    );
endmodule

// File: tb/tb_dp_ram_stream_reader.sv
// tb/tb_dp_ram_stream_reader.sv - reader integrated with a real dp_ram preloaded with RAM[i]=i
module tb_dp_ram_stream_reader;
    import dp_ram_pkg::*;

    localparam int DW = 8;
    localparam int DEPTH = 256;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy, done;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          we_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] din_a;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dp_ram_stream_reader_if #(.DATA_WIDTH(DW)) strm ();

    dp_ram #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) ram (
        .clk   (clk),
        .we_a  (we_a),
        .addr_a(addr_a),
        .din_a (din_a),
        .addr_b(rd_addr),
        .dout_b(rd_data)
    );

    dp_ram_stream_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .Clk      (clk),
        .Rst_n    (rst_n),
        .start    (start),
        .base_addr(base_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .m        (strm)
    );

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        expect_eq({tag, ".busy0"},    32'(busy), 32'd0);
        expect_eq({tag, ".done0"},    32'(done), 32'd0);
        expect_eq({tag, ".valid0"},   32'(strm.m_valid), 32'd0);
        expect_eq({tag, ".last0"},    32'(strm.m_last), 32'd0);
        expect_eq({tag, ".data0"},    32'(strm.m_data), 32'd0);
        expect_eq({tag, ".rd_addr0"}, 32'(rd_addr), 32'd0);
    endtask

    // mode 0: m_ready always high; mode 1: toggle to cycle 11, low 12..21, high after
    task automatic run_cmd(input string tag, input logic [7:0] base, input int len,
                           input int mode, input int restart_cyc, input int reset_cyc);
        int nbeats = 0;
        int first_cyc = -1;
        int done_cyc = -1;
        logic [7:0] exp_data;
        @(posedge clk); #1;
        strm.m_ready = (mode == 0);
        start        = 1'b1;
        base_addr    = base;
        length       = 9'(len);
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            if (mode == 1) strm.m_ready = (c < 12) ? (c % 2 == 1) : (c >= 22);
            else strm.m_ready = 1'b1;
            start = (c == restart_cyc);
            if (c == restart_cyc) begin
                base_addr = base + 8'h35;
                length    = 9'd3;
            end
            if (c == reset_cyc) begin
                #2 rst_n = 1'b0;
                #1 check_idle_outputs({tag, ".async"});
                return;
            end
            @(negedge clk);
            expect_eq({tag, ".busy"}, 32'(busy), 32'd1);
            expect_eq({tag, ".occ_le4"}, 32'(dut.occupancy <= 3'd4), 32'd1);
            if (len == 0) expect_eq({tag, ".no_valid"}, 32'(strm.m_valid), 32'd0);
            if (mode == 0 && c <= len) expect_eq({tag, ".rd_addr"}, 32'(rd_addr), 32'(8'(base + 8'(c - 1))));
            if (strm.m_valid) begin
                exp_data = 8'(base + 8'(nbeats));
                expect_eq({tag, ".data"}, 32'(strm.m_data), 32'(exp_data));
                expect_eq({tag, ".last"}, 32'(strm.m_last), 32'(nbeats == len - 1));
                if (strm.m_ready) begin
                    if (first_cyc < 0) first_cyc = c;
                    nbeats++;
                end
            end
            if (done) begin
                done_cyc = c;
                break;
            end
            @(posedge clk); #1;
        end
        expect_eq({tag, ".done_seen"}, 32'(done_cyc >= 0), 32'd1);
        expect_eq({tag, ".beats"}, 32'(nbeats), 32'(len));
        if (mode == 0) expect_eq({tag, ".done_cyc"}, 32'(done_cyc), 32'((len == 0) ? 1 : len + 3));
        if (mode == 0 && len > 0) expect_eq({tag, ".first_cyc"}, 32'(first_cyc), 32'd3);
        @(posedge clk); #1;
        @(negedge clk);
        expect_eq({tag, ".busy_fall"}, 32'(busy), 32'd0);
        expect_eq({tag, ".done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        base_addr    = '0;
        length       = '0;
        strm.m_ready = 1'b0;
        we_a         = 1'b0;
        addr_a       = '0;
        din_a        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            @(posedge clk); #1;
            we_a   = 1'b1;
            addr_a = 8'(i);
            din_a  = 8'(i);
        end
        @(posedge clk); #1;
        we_a = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_cmd("base10",  8'h10, 4,   0, 0, 0);
        run_cmd("wrap",    8'hFE, 4,   0, 0, 0);
        run_cmd("bp",      8'h30, 8,   1, 0, 0);
        run_cmd("len0",    8'h50, 0,   0, 0, 0);
        run_cmd("restart", 8'h20, 6,   0, 2, 0);
        run_cmd("rst",     8'h80, 16,  0, 0, 5);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_cmd("after_rst", 8'h40, 2, 0, 0, 0);
        run_cmd("full",    8'h9C, 256, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
